// File: rtl/mem_burst_if.sv
// Memory-side bus between the burst initiator (master) and the single-port
// valid/ready memory responder (slave).
interface mem_burst_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_w_data;
  logic                  mem_wr_rd;
  logic                  mem_valid;
  logic [WIDTH-1:0]      mem_r_data;
  logic                  mem_ready;

  modport master (
    output mem_addr, mem_w_data, mem_wr_rd, mem_valid,
    input  mem_r_data, mem_ready
  );

  modport slave (
    input  mem_addr, mem_w_data, mem_wr_rd, mem_valid,
    output mem_r_data, mem_ready
  );
endinterface

// File: rtl/mem_burst_initiator.sv
// Burst initiator: takes one host command, issues one valid pulse per beat to
// the memory, streams read data back and reports completion or timeout.
module mem_burst_initiator #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int LEN_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [WIDTH-1:0]      cmd_seed_i,
  mem_burst_if.master           mem,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            dbg_state_o
);
  // Handshakes: a command transfers on the rising edge where cmd_valid_i and
  // cmd_ready_o are both high; a memory beat is one mem_valid cycle followed
  // by WAIT until the responder raises mem_ready for one cycle.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                state_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  valid_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [TW-1:0]         to_q;
  logic [WIDTH-1:0]      rd_data_q;
  logic                  rd_valid_q;
  logic                  done_q;
  logic                  err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      valid_q    <= 1'b0;
      len_q      <= '0;
      beat_q     <= '0;
      to_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            wr_q    <= cmd_wr_i;
            addr_q  <= cmd_addr_i;
            len_q   <= cmd_len_i;
            beat_q  <= '0;
            valid_q <= 1'b1;
            if (cmd_wr_i) wdata_q <= cmd_seed_i;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          valid_q <= 1'b0;
          to_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem.mem_ready) begin
            if (!wr_q) begin
              rd_data_q  <= mem.mem_r_data;
              rd_valid_q <= 1'b1;
            end
            if (beat_q == len_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              // Address and data wrap naturally at their register widths.
              addr_q  <= addr_q + 1'b1;
              if (wr_q) wdata_q <= wdata_q + 1'b1;
              beat_q  <= beat_q + 1'b1;
              valid_q <= 1'b1;
              state_q <= ISSUE;
            end
          end else if (to_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign dbg_state_o    = state_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_w_data = wdata_q;
  assign mem.mem_wr_rd  = wr_q;
  assign mem.mem_valid  = valid_q;
  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_mem_burst_initiator.sv
// Directed bench for mem_burst_initiator against a one-edge-latency responder.
module tb_mem_burst_initiator;
  localparam int WIDTH   = 8;
  localparam int AW      = 3;
  localparam int LW      = 4;
  localparam int TIMEOUT = 15;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_wr = 1'b0;
  logic [AW-1:0]    cmd_addr = '0;
  logic [LW-1:0]    cmd_len = '0;
  logic [WIDTH-1:0] cmd_seed = '0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, busy, done, err;
  logic [1:0]       dbg_state;

  mem_burst_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

  mem_burst_initiator #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed),
    .mem(bus.master),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .busy_o(busy),
    .done_o(done), .err_o(err), .dbg_state_o(dbg_state)
  );

  // Responder model: ready and read data follow valid by one edge.
  logic [WIDTH-1:0] model_mem [0:7];
  bit resp_en = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_ready  <= 1'b0;
      bus.mem_r_data <= '0;
    end else begin
      bus.mem_ready <= 1'b0;
      if (bus.mem_valid && resp_en) begin
        bus.mem_ready <= 1'b1;
        if (!bus.mem_wr_rd) bus.mem_r_data <= model_mem[bus.mem_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.mem_valid && resp_en && bus.mem_wr_rd) model_mem[bus.mem_addr] <= bus.mem_w_data;
  end

  // Monitor: edge numbering, accepts, valid pulses, read beats, done pulses.
  int edge_cnt = 0, acc_cnt = 0, acc_edge = 0, done_cnt = 0, done_edge = 0, consec = 0;
  logic done_err = 1'b0;
  logic prev_valid = 1'b0;
  logic [AW-1:0]    va_q[$];
  logic [WIDTH-1:0] vd_q[$];
  logic             vw_q[$];
  int               ve_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] rd_q[$];
  int               re_q[$];

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      acc_cnt  <= acc_cnt + 1;
      acc_edge <= edge_cnt + 1;
    end
    edge_cnt <= edge_cnt + 1;
    #1;
    if (bus.mem_valid) begin
      va_q.push_back(bus.mem_addr);
      vd_q.push_back(bus.mem_w_data);
      vw_q.push_back(bus.mem_wr_rd);
      ve_q.push_back(edge_cnt);
      if (prev_valid) consec++;
    end
    prev_valid = bus.mem_valid;
    if (rd_valid) begin
      rd_q.push_back(rd_data);
      re_q.push_back(edge_cnt);
    end
    if (done) begin
      done_cnt++;
      done_edge = edge_cnt;
      done_err  = err;
    end
  end

  int checks = 0;
  int errors = 0;

  // Driver tasks
  task automatic clear_mon();
    va_q.delete(); vd_q.delete(); vw_q.delete(); ve_q.delete();
    rd_q.delete(); re_q.delete(); exp_q.delete();
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [WIDTH-1:0] s, output bit ok);
    int start;
    start = acc_cnt;
    ok = 1'b0;
    @(negedge clk);
    cmd_wr = wr; cmd_addr = a; cmd_len = l; cmd_seed = s; cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Tests
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if ({bus.mem_valid, bus.mem_wr_rd, rd_valid, done, err, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000", {bus.mem_valid, bus.mem_wr_rd, rd_valid, done, err, busy}); end
    checks++; if (bus.mem_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr); end
    checks++; if (bus.mem_w_data !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", bus.mem_w_data); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_burst();
    logic [AW-1:0] ea [4];
    bit ok;
    int d0;
    ea = '{3'd6, 3'd7, 3'd0, 3'd1};
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    clear_mon();
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    d0 = done_cnt;
    send_cmd(1'b1, 3'd6, 4'd3, 8'hFE, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_accept: got no accept expected accept"); end
    wait_done(d0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_done_timeout: got no done expected done"); end
    checks++; if (va_q.size() != 4) begin errors++; $display("FAIL wr_beats: got %0d expected 4", va_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < va_q.size()) begin
        checks++; if (va_q[i] !== ea[i]) begin errors++; $display("FAIL wr_addr[%0d]: got %0d expected %0d", i, va_q[i], ea[i]); end
        checks++; if (vd_q[i] !== exp_q[i]) begin errors++; $display("FAIL wr_data[%0d]: got %0h expected %0h", i, vd_q[i], exp_q[i]); end
        checks++; if (vw_q[i] !== 1'b1) begin errors++; $display("FAIL wr_wr_rd[%0d]: got %b expected 1", i, vw_q[i]); end
        checks++; if (ve_q[i] != acc_edge + 2 * i) begin errors++; $display("FAIL wr_edge[%0d]: got %0d expected %0d", i, ve_q[i], acc_edge + 2 * i); end
      end
    end
    checks++; if (done_edge != acc_edge + 8) begin errors++; $display("FAIL wr_done_edge: got %0d expected %0d", done_edge, acc_edge + 8); end
    checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", done_err); end
    checks++; if (rd_q.size() != 0) begin errors++; $display("FAIL wr_rd_valid: got %0d pulses expected 0", rd_q.size()); end
    checks++; if (consec != 0) begin errors++; $display("FAIL wr_valid_spacing: got %0d back-to-back expected 0", consec); end
  endtask

  task automatic test_read_burst();
    bit ok;
    int d0;
    clear_mon();
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    d0 = done_cnt;
    send_cmd(1'b0, 3'd6, 4'd3, 8'h00, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_accept: got no accept expected accept"); end
    wait_done(d0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_done_timeout: got no done expected done"); end
    checks++; if (rd_q.size() != 4) begin errors++; $display("FAIL rd_beats: got %0d expected 4", rd_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < rd_q.size()) begin
        checks++; if (rd_q[i] !== exp_q[i]) begin errors++; $display("FAIL rd_data[%0d]: got %0h expected %0h", i, rd_q[i], exp_q[i]); end
        checks++; if (re_q[i] != acc_edge + 2 * (i + 1)) begin errors++; $display("FAIL rd_edge[%0d]: got %0d expected %0d", i, re_q[i], acc_edge + 2 * (i + 1)); end
        checks++; if (vw_q[i] !== 1'b0) begin errors++; $display("FAIL rd_wr_rd[%0d]: got %b expected 0", i, vw_q[i]); end
      end
    end
    checks++; if (done_edge != acc_edge + 8) begin errors++; $display("FAIL rd_done_edge: got %0d expected %0d", done_edge, acc_edge + 8); end
    checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", done_err); end
  endtask

  task automatic test_back_to_back();
    int start, d0, first_acc, second_acc;
    bit ok;
    clear_mon();
    start = acc_cnt;
    d0 = done_cnt;
    @(negedge clk);
    cmd_wr = 1'b1; cmd_addr = 3'd2; cmd_len = 4'd3; cmd_seed = 8'h10; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && acc_cnt == start; i++) @(negedge clk);
    first_acc = acc_edge;
    cmd_wr = 1'b0; cmd_addr = 3'd2; cmd_len = 4'd1; cmd_seed = 8'h99;
    for (int i = 0; i < 200 && acc_cnt == start + 1; i++) @(negedge clk);
    second_acc = acc_edge;
    cmd_valid = 1'b0;
    checks++; if (acc_cnt != start + 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc_cnt - start); end
    checks++; if (second_acc != first_acc + 10) begin errors++; $display("FAIL b2b_second_accept: got %0d expected %0d", second_acc, first_acc + 10); end
    wait_done(d0 + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: got no done expected done"); end
    checks++; if (done_edge != second_acc + 4) begin errors++; $display("FAIL b2b_done_edge: got %0d expected %0d", done_edge, second_acc + 4); end
    checks++; if (va_q.size() != 6) begin errors++; $display("FAIL b2b_beats: got %0d expected 6", va_q.size()); end
    if (va_q.size() == 6) begin
      checks++; if (vd_q[3] !== 8'h13) begin errors++; $display("FAIL b2b_last_wdata: got %0h expected 13", vd_q[3]); end
      checks++; if ({va_q[4], vw_q[4], va_q[5], vw_q[5]} !== {3'd2, 1'b0, 3'd3, 1'b0}) begin
        errors++; $display("FAIL b2b_second_cmd: got %0d/%b %0d/%b expected 2/0 3/0", va_q[4], vw_q[4], va_q[5], vw_q[5]); end
    end
    checks++; if (rd_q.size() != 2) begin errors++; $display("FAIL b2b_rd_beats: got %0d expected 2", rd_q.size()); end
    if (rd_q.size() == 2) begin
      checks++; if ({rd_q[0], rd_q[1]} !== {8'h10, 8'h11}) begin errors++; $display("FAIL b2b_rd_data: got %0h %0h expected 10 11", rd_q[0], rd_q[1]); end
    end
  endtask

  task automatic test_single_beat();
    bit ok;
    int d0;
    clear_mon();
    d0 = done_cnt;
    send_cmd(1'b0, 3'd2, 4'd0, 8'h00, ok);
    wait_done(d0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout: got no done expected done"); end
    checks++; if (done_edge != acc_edge + 2) begin errors++; $display("FAIL single_done_edge: got %0d expected %0d", done_edge, acc_edge + 2); end
    checks++; if (va_q.size() != 1) begin errors++; $display("FAIL single_beats: got %0d expected 1", va_q.size()); end
    checks++; if (rd_q.size() != 1) begin errors++; $display("FAIL single_rd_beats: got %0d expected 1", rd_q.size()); end
    if (rd_q.size() == 1) begin
      checks++; if (rd_q[0] !== 8'h10) begin errors++; $display("FAIL single_rd_data: got %0h expected 10", rd_q[0]); end
      checks++; if (re_q[0] != acc_edge + 2) begin errors++; $display("FAIL single_rd_edge: got %0d expected %0d", re_q[0], acc_edge + 2); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int d0;
    clear_mon();
    resp_en = 1'b0;
    d0 = done_cnt;
    send_cmd(1'b1, 3'd5, 4'd3, 8'h77, ok);
    wait_done(d0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_done_timeout: got no done expected done"); end
    checks++; if (va_q.size() != 1) begin errors++; $display("FAIL to_beats: got %0d expected 1", va_q.size()); end
    checks++; if (done_edge != acc_edge + TIMEOUT + 1) begin errors++; $display("FAIL to_done_edge: got %0d expected %0d", done_edge, acc_edge + TIMEOUT + 1); end
    checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", done_err); end
    resp_en = 1'b1;
    clear_mon();
    d0 = done_cnt;
    send_cmd(1'b0, 3'd3, 4'd0, 8'h00, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_next_accept: got no accept expected accept"); end
    wait_done(d0, ok);
    checks++; if (done_edge != acc_edge + 2 || done_err !== 1'b0) begin
      errors++; $display("FAIL to_next_done: got edge %0d err %b expected edge %0d err 0", done_edge, done_err, acc_edge + 2); end
    checks++; if (rd_q.size() != 1 || rd_q[0] !== 8'h11) begin
      errors++; $display("FAIL to_next_rd: got %0d beats expected 1 beat of 11", rd_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int d0;
    clear_mon();
    d0 = done_cnt;
    send_cmd(1'b0, 3'd6, 4'd3, 8'h00, ok);
    for (int i = 0; i < 50 && edge_cnt < acc_edge + 3; i++) @(negedge clk);
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL mid_state_before: got %0d expected 2", dbg_state); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.mem_valid, bus.mem_wr_rd, rd_valid, done, err, busy} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_flags: got %b expected 000000", {bus.mem_valid, bus.mem_wr_rd, rd_valid, done, err, busy}); end
    checks++; if ({bus.mem_addr, bus.mem_w_data, rd_data} !== '0) begin
      errors++; $display("FAIL mid_reset_data: got %0h %0h %0h expected 0 0 0", bus.mem_addr, bus.mem_w_data, rd_data); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", cmd_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL mid_no_done: got %0d done pulses expected 0", done_cnt - d0); end
    checks++; if (rd_q.size() != 1) begin errors++; $display("FAIL mid_rd_beats: got %0d expected 1", rd_q.size()); end
    clear_mon();
    send_cmd(1'b1, 3'd3, 4'd1, 8'h40, ok);
    wait_done(d0, ok);
    checks++; if (!ok || done_edge != acc_edge + 4 || done_err !== 1'b0) begin
      errors++; $display("FAIL mid_after_done: got edge %0d err %b expected edge %0d err 0", done_edge, done_err, acc_edge + 4); end
    checks++; if (va_q.size() != 2) begin errors++; $display("FAIL mid_after_beats: got %0d expected 2", va_q.size()); end
    if (va_q.size() == 2) begin
      checks++; if ({va_q[0], vd_q[0], va_q[1], vd_q[1]} !== {3'd3, 8'h40, 3'd4, 8'h41}) begin
        errors++; $display("FAIL mid_after_beats_val: got %0d/%0h %0d/%0h expected 3/40 4/41", va_q[0], vd_q[0], va_q[1], vd_q[1]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_back_to_back();
    test_single_beat();
    test_timeout();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
